// File: rtl/elevator_car_drive.sv
// Car-motion responder for the three-floor elevator: accepts one target floor at a time,
// steps the car floor by floor with a fixed travel time, then holds the door for a fixed dwell.
//
// state | meaning
// IDLE  | parked with the door closed, req_ready high
// MOVE  | travelling toward t_f, one floor per TRAVEL_CYCLES
// DOOR  | door open at the target floor for DOOR_CYCLES
module elevator_car_drive #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_floor,
    output logic       req_ready,
    output logic [1:0] c_f,
    output logic [1:0] t_f,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       arrive,
    output logic       req_err
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] TRAV_LAST  = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MOVE = 2'b01,
        DOOR = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] trav_cnt;
    logic [TW-1:0] trav_cnt_nxt;
    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] dwell_cnt_nxt;

    logic [1:0] c_f_nxt;
    logic [1:0] t_f_nxt;
    logic       moving_up_nxt;
    logic       moving_down_nxt;
    logic       door_open_nxt;
    logic       arrive_nxt;
    logic       req_err_nxt;

    logic       accept;
    logic       legal;
    logic       trav_tc;
    logic       dwell_tc;
    logic [1:0] floor_step;
    logic       arrive_hit;

    assign accept   = req_valid && (state == IDLE);
    assign legal    = (req_floor != 2'b11);
    assign trav_tc  = (state == MOVE) && (trav_cnt == TRAV_LAST);
    assign dwell_tc = (state == DOOR) && (dwell_cnt == DWELL_LAST);

    // The step saturates at the shaft ends, so a corrupted direction can never push c_f to 11.
    always_comb begin
        floor_step = c_f;
        if (moving_up && (c_f != 2'b10)) begin
            floor_step = c_f + 2'd1;
        end else if (moving_down && (c_f != 2'b00)) begin
            floor_step = c_f - 2'd1;
        end
    end

    // A step that cannot move the car also ends the trip, so MOVE never stalls.
    assign arrive_hit = (floor_step == t_f) || (floor_step == c_f);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            trav_cnt    <= '0;
            dwell_cnt   <= '0;
            c_f         <= 2'b00;
            t_f         <= 2'b00;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
            arrive      <= 1'b0;
            req_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            trav_cnt    <= trav_cnt_nxt;
            dwell_cnt   <= dwell_cnt_nxt;
            c_f         <= c_f_nxt;
            t_f         <= t_f_nxt;
            moving_up   <= moving_up_nxt;
            moving_down <= moving_down_nxt;
            door_open   <= door_open_nxt;
            arrive      <= arrive_nxt;
            req_err     <= req_err_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_nxt = (req_floor == c_f) ? DOOR : MOVE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MOVE: state_nxt = (trav_tc && arrive_hit) ? DOOR : MOVE;
            DOOR: state_nxt = dwell_tc ? IDLE : DOOR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        c_f_nxt         = c_f;
        t_f_nxt         = t_f;
        moving_up_nxt   = 1'b0;
        moving_down_nxt = 1'b0;
        arrive_nxt      = 1'b0;
        req_err_nxt     = 1'b0;
        trav_cnt_nxt    = '0;
        dwell_cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        req_err_nxt = 1'b1;
                    end else begin
                        t_f_nxt = req_floor;
                        if (req_floor > c_f) begin
                            moving_up_nxt = 1'b1;
                        end else if (req_floor < c_f) begin
                            moving_down_nxt = 1'b1;
                        end else begin
                            arrive_nxt = 1'b1;
                        end
                    end
                end
            end
            MOVE: begin
                if (trav_tc) begin
                    c_f_nxt = floor_step;
                    if (arrive_hit) begin
                        arrive_nxt = 1'b1;
                    end else begin
                        moving_up_nxt   = moving_up;
                        moving_down_nxt = moving_down;
                    end
                end else begin
                    trav_cnt_nxt    = trav_cnt + TW'(1);
                    moving_up_nxt   = moving_up;
                    moving_down_nxt = moving_down;
                end
            end
            DOOR: begin
                if (!dwell_tc) begin
                    dwell_cnt_nxt = dwell_cnt + DW'(1);
                end
            end
            default: begin
            end
        endcase
        door_open_nxt = (state_nxt == DOOR);
    end

    assign req_ready = (state == IDLE);

endmodule

// File: tb/tb_elevator_car_drive.sv
// Directed bench for elevator_car_drive with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_car_drive;

    localparam int TC = 4;
    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_floor = 2'b00;
    logic       req_ready;
    logic [1:0] c_f;
    logic [1:0] t_f;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic       arrive;
    logic       req_err;

    int n_cmp = 0;
    int n_err = 0;

    elevator_car_drive #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .req_ready   (req_ready),
        .c_f         (c_f),
        .t_f         (t_f),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .arrive      (arrive),
        .req_err     (req_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s k=%0d: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input int k, input logic [1:0] floor_exp);
        chk({tag, "_cf"}, k, 8'(c_f), 8'(floor_exp));
        chk({tag, "_ready"}, k, 8'(req_ready), 8'd1);
        chk({tag, "_flags"}, k, 8'({moving_up, moving_down, door_open, arrive, req_err}), 8'd0);
    endtask

    // Request already presented at the current negedge; checks every cycle until the door closes.
    task automatic trip(input int s, input int t);
        int d;
        int steps;
        int cf_exp;
        d = (t > s) ? (t - s) : (s - t);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k <= d * TC + DC; k++) begin
            if (k > 0) @(negedge clk);
            steps  = (k / TC < d) ? (k / TC) : d;
            cf_exp = (t > s) ? (s + steps) : (s - steps);
            chk("trip_cf",    k, 8'(c_f),         8'(cf_exp));
            chk("trip_tf",    k, 8'(t_f),         8'(t));
            chk("trip_up",    k, 8'(moving_up),   8'((t > s) && (k < d * TC)));
            chk("trip_down",  k, 8'(moving_down), 8'((t < s) && (k < d * TC)));
            chk("trip_arr",   k, 8'(arrive),      8'(k == d * TC));
            chk("trip_door",  k, 8'(door_open),   8'((k >= d * TC) && (k < d * TC + DC)));
            chk("trip_ready", k, 8'(req_ready),   8'(k >= d * TC + DC));
            chk("trip_err",   k, 8'(req_err),     8'd0);
        end
    endtask

    initial begin
        // 1: reset values, then 10 quiet cycles
        #1;
        chk_idle_outputs("rst", 0, 2'b00);
        chk("rst_tf", 0, 8'(t_f), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_idle_outputs("quiet", k, 2'b00);
        end

        // 2: 00 -> 10
        req_valid = 1'b1; req_floor = 2'b10;
        trip(0, 2);

        // 3: 10 -> 00
        req_valid = 1'b1; req_floor = 2'b00;
        trip(2, 0);

        // 4: 00 -> 01, then same-floor 01
        req_valid = 1'b1; req_floor = 2'b01;
        trip(0, 1);
        req_valid = 1'b1; req_floor = 2'b01;
        trip(1, 1);

        // 5: illegal floor, then a legal request on the very next edge
        req_valid = 1'b1; req_floor = 2'b11;
        @(negedge clk);
        chk("ill_err",   0, 8'(req_err),   8'd1);
        chk("ill_ready", 0, 8'(req_ready), 8'd1);
        chk("ill_cf",    0, 8'(c_f),       8'd1);
        chk("ill_tf",    0, 8'(t_f),       8'd1);
        chk("ill_arr",   0, 8'(arrive),    8'd0);
        req_floor = 2'b00;
        trip(1, 0);

        // 6: ignored request mid-MOVE, then asynchronous reset mid-MOVE
        req_valid = 1'b1; req_floor = 2'b10;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (TC) @(negedge clk);
        chk("mid_cf", 0, 8'(c_f), 8'd1);
        req_valid = 1'b1; req_floor = 2'b00;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("ign_ready", k, 8'(req_ready),   8'd0);
            chk("ign_tf",    k, 8'(t_f),         8'd2);
            chk("ign_up",    k, 8'(moving_up),   8'd1);
            chk("ign_down",  k, 8'(moving_down), 8'd0);
            chk("ign_cf",    k, 8'(c_f),         8'd1);
        end
        req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_idle_outputs("arst", 0, 2'b00);
        chk("arst_tf", 0, 8'(t_f), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post", 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/elevator_car_drive.md
# elevator_car_drive

Car-motion responder for the three-floor elevator controller. Accepts a target-floor request from the floor-selection FSM over a valid/ready handshake. Steps the car one floor at a time with a fixed travel time per floor, then holds the door open for a fixed dwell. Reports the current floor, direction, door state and an arrival pulse back to the selection logic and the LED/display path.

## Interface
Parameters:
- TRAVEL_CYCLES, 8: clock cycles to travel one floor; legal range ≥ 2.
- DOOR_CYCLES, 6: clock cycles the door stays open on arrival; legal range ≥ 1.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- req_valid  in  1  target-floor request valid.
- req_floor  in  2  target floor: 00 ground, 01 first, 10 second; 11 is illegal.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
- c_f  out  2  current floor, registered.
- t_f  out  2  latched target floor, registered.
- moving_up  out  1  car travelling upward.
- moving_down  out  1  car travelling downward.
- door_open  out  1  door open.
- arrive  out  1  one-cycle pulse when the car reaches the target floor.
- req_err  out  1  one-cycle pulse when an illegal floor (11) is presented and accepted.

## Operation
- States:
  - IDLE: req_ready=1.
  - MOVE: travelling between floors.
  - DOOR: door dwell at the target floor.
- IDLE, on an accepted request:
  - req_floor==11: stay in IDLE; req_err pulses next cycle; t_f is unchanged.
  - req_floor==c_f: go to DOOR; t_f←req_floor; arrive pulses.
  - req_floor>c_f: go to MOVE; moving_up=1; t_f←req_floor.
  - req_floor<c_f: go to MOVE; moving_down=1; t_f←req_floor.
- MOVE:
  - A travel counter counts 0..TRAVEL_CYCLES-1.
  - At terminal count, c_f steps ±1 and the counter clears.
  - If the new c_f equals t_f, go to DOOR: assert arrive for one cycle, clear moving_up and moving_down, assert door_open.
  - Otherwise stay in MOVE; the 00→10 trip passes through 01.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, counted by a dwell counter.
  - Then go to IDLE; door_open=0 and req_ready=1.
- Requests are never queued. req_valid outside IDLE is ignored, and a request dropped before acceptance is lost.
- c_f is never outside 00..10. Direction is fixed at acceptance; moving_up and moving_down are never both 1.
- Undefined state encodings recover to IDLE with c_f unchanged.

## Timing
- Reset values while reset=0: state IDLE, c_f=00, t_f=00, req_ready=1, moving_up=0, moving_down=0, door_open=0, arrive=0, req_err=0, all counters 0.
- Reset is asynchronous. Asserting it mid-MOVE or mid-DOOR forces the reset values immediately; the car position is re-initialised to ground.
- All outputs are registered except req_ready, which is decoded from state (state==IDLE).
- Request accepted at edge E0, distance d floors (d=1 or 2):
  - moving_* is high from E0.
  - c_f changes at edges E0+k·TRAVEL_CYCLES, for k=1..d.
  - arrive and door_open rise at E0+d·TRAVEL_CYCLES.
  - door_open falls, and req_ready rises, at E0+d·TRAVEL_CYCLES+DOOR_CYCLES.
- Same-floor request accepted at E0: arrive and door_open rise at E0; req_ready returns at E0+DOOR_CYCLES.
- Illegal request accepted at E0: req_err high for the cycle after E0; req_ready stays 1; the next request can be accepted at E0+1.
- A new request may be accepted on the first IDLE edge after the door closes; there are no extra turnaround cycles.
- arrive is exactly one cycle wide per trip. req_err is exactly one cycle wide per illegal request.

## Test plan
All scenarios use TRAVEL_CYCLES=4 and DOOR_CYCLES=3.
1. Reset, then hold for 10 cycles → c_f=00, req_ready=1, all other outputs 0 throughout.
2. Request 10 from floor 00, accepted at E0:
   - c_f=01 at E0+4 and 10 at E0+8.
   - moving_up=1 during E0..E0+8.
   - arrive pulse at E0+8; door_open=1 for E0+8..E0+11; req_ready=1 at E0+11.
3. Request 00 from floor 10:
   - moving_down=1; c_f goes 01 then 00 at 4-cycle spacing.
   - arrive once; moving_up never asserts.
4. Same-floor request 01 while c_f=01:
   - arrive and door_open at the accept edge; c_f unchanged.
   - req_ready=0 for 3 cycles.
5. req_floor=11 in IDLE → req_err pulses 1 cycle; state, c_f and t_f unchanged; a legal request on the next cycle is accepted.
6. Request 10 from floor 00; after c_f reaches 01, toggle req_valid with floor 00 (expect it ignored, req_ready=0), then assert reset mid-MOVE → all outputs return to reset values immediately, c_f=00, req_ready=1.
